row_cmd_sequencer: RTL and testbench

Command-issuing side of the open-row protocol. It accepts read/write requests carrying a row and column. It drives `requested_row`, `row_activate` and `row_precharge` into the row buffer manager, and reads back `row_open` and `row_hit`. It enforces the ACT/PRE/column timing (tRCD, tRP, tRAS), then emits a one-cycle read or write column strobe. One request is in flight at a time; it sits between the request front-end and the DRAM PHY command path.

---
 rtl/membridge_pkg.sv | 30 +++
 rtl/row_cmd_sequencer_if.sv | 32 +++
 rtl/timing_counter.sv | 32 +++
 rtl/row_cmd_sequencer.sv | 154 +++++++++++++++
 tb/tb_row_cmd_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/membridge_pkg.sv
// Shared memory-bridge definitions: default widths and DRAM timings, plus
// the state encoding of the row command sequencer.
package membridge_pkg;

  localparam int DEF_ROW_W = 16;
  localparam int DEF_COL_W = 10;
  localparam int DEF_T_RCD = 3;
  localparam int DEF_T_RP  = 3;
  localparam int DEF_T_RAS = 8;
  localparam int DEF_CNT_W = 4;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DECIDE   = 3'd1;
  localparam logic [2:0] ST_PRE      = 3'd2;
  localparam logic [2:0] ST_WAIT_RP  = 3'd3;
  localparam logic [2:0] ST_ACT      = 3'd4;
  localparam logic [2:0] ST_WAIT_RCD = 3'd5;
  localparam logic [2:0] ST_ISSUE    = 3'd6;

  typedef enum logic [2:0] {
    SEQ_IDLE     = ST_IDLE,
    SEQ_DECIDE   = ST_DECIDE,
    SEQ_PRE      = ST_PRE,
    SEQ_WAIT_RP  = ST_WAIT_RP,
    SEQ_ACT      = ST_ACT,
    SEQ_WAIT_RCD = ST_WAIT_RCD,
    SEQ_ISSUE    = ST_ISSUE
  } seq_state_e;

endpackage

// File: rtl/row_cmd_sequencer_if.sv
// Request channel between the front-end (master) and the row command
// sequencer (slave): valid/ready handshake carrying direction, row and column.
interface row_cmd_sequencer_if
  import membridge_pkg::*;
#(
  parameter int ROW_W = DEF_ROW_W,
  parameter int COL_W = DEF_COL_W
) ();

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;

  modport master (
    output req_valid,
    output req_we,
    output req_row,
    output req_col,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_row,
    input  req_col,
    output req_ready
  );

endinterface

// File: rtl/timing_counter.sv
// Loadable saturating down-counter; done flags that the interval expires at
// the coming clock edge, so a load of N-1 lets the FSM leave after N cycles.
module timing_counter #(
  parameter int CNT_W = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  // Load has priority; otherwise count down and stick at zero.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r <= CNT_ONE);

endmodule

// File: rtl/row_cmd_sequencer.sv
// Row command sequencer: turns single read/write requests into PRE/ACT and
// column strobes against the row buffer manager, honouring tRCD, tRP and tRAS.
module row_cmd_sequencer
  import membridge_pkg::*;
#(
  parameter int ROW_W = DEF_ROW_W,
  parameter int COL_W = DEF_COL_W,
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_RP  = DEF_T_RP,
  parameter int T_RAS = DEF_T_RAS,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  row_cmd_sequencer_if.slave fe,
  input  logic               row_open,
  input  logic               row_hit,
  output logic [ROW_W-1:0]   requested_row,
  output logic               row_activate,
  output logic               row_precharge,
  output logic               cmd_rd,
  output logic               cmd_wr,
  output logic [COL_W-1:0]   cmd_col
);

  localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RAS_LOAD = CNT_W'(T_RAS - 1);

  seq_state_e       state_r;
  seq_state_e       state_s;
  logic             we_r;
  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] col_r;
  logic             accept_s;
  logic             wait_load_s;
  logic [CNT_W-1:0] wait_val_s;
  logic             wait_done_s;
  logic             ras_load_s;
  logic             ras_done_s;
  logic             ready_r;
  logic             act_r;
  logic             pre_r;
  logic             rd_r;
  logic             wr_r;

  assign accept_s   = fe.req_valid && (state_r == SEQ_IDLE);
  assign ras_load_s = (state_r == SEQ_ACT);

  // One counter serves both tRP and tRCD: those waits never overlap.
  timing_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .load     (wait_load_s),
    .load_val (wait_val_s),
    .done     (wait_done_s)
  );

  timing_counter #(.CNT_W(CNT_W)) u_ras_cnt (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .load     (ras_load_s),
    .load_val (RAS_LOAD),
    .done     (ras_done_s)
  );

  // Next-state decode and wait-timer loads.
  always_comb begin
    state_s     = state_r;
    wait_load_s = 1'b0;
    wait_val_s  = {CNT_W{1'b0}};
    case (state_r)
      SEQ_IDLE: begin
        if (accept_s) state_s = SEQ_DECIDE;
        else          state_s = SEQ_IDLE;
      end
      SEQ_DECIDE: begin
        if (row_hit)         state_s = SEQ_ISSUE;
        else if (!row_open)  state_s = SEQ_ACT;
        else if (ras_done_s) state_s = SEQ_PRE;
        else                 state_s = SEQ_DECIDE;
      end
      SEQ_PRE: begin
        wait_load_s = 1'b1;
        wait_val_s  = RP_LOAD;
        if (T_RP == 1) state_s = SEQ_ACT;
        else           state_s = SEQ_WAIT_RP;
      end
      SEQ_WAIT_RP: begin
        if (wait_done_s) state_s = SEQ_ACT;
        else             state_s = SEQ_WAIT_RP;
      end
      SEQ_ACT: begin
        wait_load_s = 1'b1;
        wait_val_s  = RCD_LOAD;
        if (T_RCD == 1) state_s = SEQ_ISSUE;
        else            state_s = SEQ_WAIT_RCD;
      end
      SEQ_WAIT_RCD: begin
        if (wait_done_s) state_s = SEQ_ISSUE;
        else             state_s = SEQ_WAIT_RCD;
      end
      SEQ_ISSUE: state_s = SEQ_IDLE;
      default:   state_s = SEQ_IDLE;
    endcase
  end

  // State register and request capture at the handshake.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r <= SEQ_IDLE;
      we_r    <= 1'b0;
      row_r   <= {ROW_W{1'b0}};
      col_r   <= {COL_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        we_r  <= fe.req_we;
        row_r <= fe.req_row;
        col_r <= fe.req_col;
      end else begin
        we_r  <= we_r;
        row_r <= row_r;
        col_r <= col_r;
      end
    end
  end

  // Moore outputs flopped from the next state so they line up with state_r.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ready_r <= 1'b1;
      act_r   <= 1'b0;
      pre_r   <= 1'b0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
    end else begin
      ready_r <= (state_s == SEQ_IDLE);
      act_r   <= (state_s == SEQ_ACT);
      pre_r   <= (state_s == SEQ_PRE);
      rd_r    <= (state_s == SEQ_ISSUE) && !we_r;
      wr_r    <= (state_s == SEQ_ISSUE) && we_r;
    end
  end

  assign fe.req_ready   = ready_r;
  assign requested_row  = row_r;
  assign row_activate   = act_r;
  assign row_precharge  = pre_r;
  assign cmd_rd         = rd_r;
  assign cmd_wr         = wr_r;
  assign cmd_col        = col_r;

endmodule

// File: tb/tb_row_cmd_sequencer.sv
// Bench for row_cmd_sequencer: directed vector table, a mid-operation reset
// sequence and randomized traffic checked against a cycle-schedule model.
module tb_row_cmd_sequencer;

  localparam int ROW_W = 16;
  localparam int COL_W = 10;
  localparam int T_RCD = 3;
  localparam int T_RP  = 3;
  localparam int T_RAS = 8;
  localparam int CNT_W = 4;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             row_open;
  logic             row_hit;
  logic [ROW_W-1:0] requested_row;
  logic             row_activate;
  logic             row_precharge;
  logic             cmd_rd;
  logic             cmd_wr;
  logic [COL_W-1:0] cmd_col;

  row_cmd_sequencer_if #(.ROW_W(ROW_W), .COL_W(COL_W)) fe ();

  row_cmd_sequencer #(
    .ROW_W(ROW_W), .COL_W(COL_W), .T_RCD(T_RCD),
    .T_RP(T_RP), .T_RAS(T_RAS), .CNT_W(CNT_W)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .fe            (fe),
    .row_open      (row_open),
    .row_hit       (row_hit),
    .requested_row (requested_row),
    .row_activate  (row_activate),
    .row_precharge (row_precharge),
    .cmd_rd        (cmd_rd),
    .cmd_wr        (cmd_wr),
    .cmd_col       (cmd_col)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Simple row buffer manager alongside the DUT.
  logic             mgr_open = 1'b0;
  logic [ROW_W-1:0] mgr_row  = '0;
  always @(posedge sys_clk) begin
    if (sys_rst) mgr_open <= 1'b0;
    else if (row_activate) begin
      mgr_open <= 1'b1;
      mgr_row  <= requested_row;
    end else if (row_precharge) mgr_open <= 1'b0;
  end
  assign row_open = mgr_open;
  assign row_hit  = mgr_open && (mgr_row == requested_row);

  int n_tests = 0;
  int n_fails = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fails++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cyc);
    end
  endtask

  // Reference model: per request, the cycles of PRE/ACT/strobe follow from
  // the accept cycle, the bank state and the cycle of the last ACT.
  int               m_free_at, m_act_at, m_pre_at, m_issue_at, m_last_act;
  logic             m_we;
  logic [COL_W-1:0] m_col;
  logic [ROW_W-1:0] m_row;
  logic             m_open;
  logic [ROW_W-1:0] m_open_row;

  task automatic model_reset();
    m_free_at  = 0;
    m_act_at   = -1;
    m_pre_at   = -1;
    m_issue_at = -1;
    m_last_act = -1000;
    m_we       = 1'b0;
    m_col      = '0;
    m_row      = '0;
    m_open     = 1'b0;
    m_open_row = '0;
  endtask

  task automatic model_step();
    int c;
    c = cyc;
    if (sys_rst) begin
      model_reset();
      return;
    end
    check("m_ready", int'(fe.req_ready), int'(c >= m_free_at));
    check("m_act", int'(row_activate), int'(c == m_act_at));
    check("m_pre", int'(row_precharge), int'(c == m_pre_at));
    check("m_rd", int'(cmd_rd), int'(c == m_issue_at && !m_we));
    check("m_wr", int'(cmd_wr), int'(c == m_issue_at && m_we));
    if (c == m_issue_at) check("m_col", int'(cmd_col), int'(m_col));
    check("m_reqrow", int'(requested_row), int'(m_row));
    if (c == m_act_at) begin
      m_open     = 1'b1;
      m_open_row = m_row;
      m_last_act = c;
    end
    if (c == m_pre_at) m_open = 1'b0;
    if (fe.req_valid && c >= m_free_at) begin
      m_we     = fe.req_we;
      m_row    = fe.req_row;
      m_col    = fe.req_col;
      m_act_at = -1;
      m_pre_at = -1;
      if (m_open && m_open_row == m_row) begin
        m_issue_at = c + 2;
      end else begin
        if (m_open) begin
          m_pre_at = (c + 2 > m_last_act + T_RAS) ? c + 2 : m_last_act + T_RAS;
          m_act_at = m_pre_at + T_RP;
        end else begin
          m_act_at = c + 2;
        end
        m_issue_at = m_act_at + T_RCD;
      end
      m_free_at = m_issue_at + 1;
    end
  endtask

  task automatic clk_drive();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge sys_clk);
    model_step();
  endtask

  task automatic do_reset();
    clk_drive(); sys_rst = 1'b1; fe.req_valid = 1'b0; sample();
    clk_drive(); sample();
    clk_drive(); sys_rst = 1'b0; sample();
    check("rst_ready", int'(fe.req_ready), 1);
    check("rst_act", int'(row_activate), 0);
    check("rst_pre", int'(row_precharge), 0);
    check("rst_rd", int'(cmd_rd), 0);
    check("rst_wr", int'(cmd_wr), 0);
    check("rst_reqrow", int'(requested_row), 0);
    check("rst_col", int'(cmd_col), 0);
  endtask

  typedef struct {
    bit               rst_before;
    bit               we;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    int               acc;
    int               act;
    int               pre;
    int               iss;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base, acc, got_act, got_pre, got_iss, got_wr, got_col, seen;
    model_reset();
    fe.req_valid = 1'b0;
    fe.req_we    = 1'b0;
    fe.req_row   = '0;
    fe.req_col   = '0;

    // Cycles relative to the first cycle after the post-reset idle cycle.
    vecs[0] = '{1'b1, 1'b0, 16'h0012, 10'd5,     0,  2, -1,  5};
    vecs[1] = '{1'b0, 1'b1, 16'h0012, 10'd9,     6, -1, -1,  8};
    vecs[2] = '{1'b1, 1'b0, 16'h0012, 10'd5,     0,  2, -1,  5};
    vecs[3] = '{1'b0, 1'b0, 16'h0034, 10'd3,     6, 13, 10, 16};
    vecs[4] = '{1'b0, 1'b1, 16'hFFFF, 10'h3FF,  17, 24, 21, 27};
    vecs[5] = '{1'b0, 1'b0, 16'hFFFF, 10'd0,    28, -1, -1, 30};

    base = 0;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].rst_before) begin
        do_reset();
        base = cyc + 1;
      end
      acc = -1;
      clk_drive();
      fe.req_valid = 1'b1;
      fe.req_we    = vecs[i].we;
      fe.req_row   = vecs[i].row;
      fe.req_col   = vecs[i].col;
      for (int k = 0; k < 64; k++) begin
        sample();
        if (fe.req_ready) begin
          acc = cyc;
          break;
        end
        clk_drive();
      end
      check($sformatf("v%0d_accept", i), (acc < 0) ? -999 : acc - base, vecs[i].acc);
      got_act = -1; got_pre = -1; got_iss = -1; got_wr = -1; got_col = -1;
      for (int k = 0; k < 64 && got_iss < 0; k++) begin
        clk_drive();
        fe.req_valid = 1'b0;
        fe.req_row   = ROW_W'($urandom);
        fe.req_col   = COL_W'($urandom);
        sample();
        if (row_activate && got_act < 0) got_act = cyc - base;
        if (row_precharge && got_pre < 0) got_pre = cyc - base;
        if (cmd_rd || cmd_wr) begin
          got_iss = cyc - base;
          got_wr  = int'(cmd_wr);
          got_col = int'(cmd_col);
        end
      end
      check($sformatf("v%0d_act", i), got_act, vecs[i].act);
      check($sformatf("v%0d_pre", i), got_pre, vecs[i].pre);
      check($sformatf("v%0d_issue", i), got_iss, vecs[i].iss);
      check($sformatf("v%0d_we", i), got_wr, int'(vecs[i].we));
      check($sformatf("v%0d_col", i), got_col, int'(vecs[i].col));
      check($sformatf("v%0d_reqrow", i), int'(requested_row), int'(vecs[i].row));
    end

    // Reset in the first WAIT_RCD cycle: the pending read must never issue.
    do_reset();
    clk_drive();
    fe.req_valid = 1'b1; fe.req_we = 1'b0; fe.req_row = 16'h0077; fe.req_col = 10'h011;
    sample();
    check("mr_accept", int'(fe.req_ready), 1);
    clk_drive(); fe.req_valid = 1'b0; sample();
    clk_drive(); sample();
    check("mr_act", int'(row_activate), 1);
    clk_drive(); sys_rst = 1'b1; sample();
    clk_drive(); sys_rst = 1'b0; sample();
    check("mr_ready", int'(fe.req_ready), 1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      clk_drive(); sample();
      if (cmd_rd || cmd_wr) seen = 1;
    end
    check("mr_no_strobe", seen, 0);

    // Randomized traffic with back-pressure and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      clk_drive();
      sys_rst      = ($urandom_range(0, 299) == 0);
      fe.req_valid = ($urandom_range(0, 3) != 0);
      fe.req_we    = 1'($urandom_range(0, 1));
      fe.req_row   = ROW_W'($urandom_range(0, 3));
      fe.req_col   = COL_W'($urandom);
      sample();
    end
    clk_drive();
    sys_rst      = 1'b0;
    fe.req_valid = 1'b0;
    sample();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
